ov7670_fifo_reader: RTL and testbench
=====================================

OV7670_FIFO_READER -- requirements
Module: ov7670_fifo_reader

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640: pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480: lines per frame.
REQ-003 SHALL have parameter RRST_CYCLES, default 4: clk25 cycles cam_rrst_n is held low per frame.
REQ-004 SHALL have port clk25, input, 1: system and FIFO read clock (cam_rclk is driven from clk25 externally).
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port frame_ready, input, 1: single-cycle pulse (clk25 domain) marking a complete frame written into the AL422B FIFO.
REQ-007 SHALL have port cam_data, input, 8: FIFO read data.
REQ-008 SHALL have port cam_rrst_n, output, 1: FIFO read-pointer reset, active-low.
REQ-009 SHALL have port cam_re_n, output, 1: FIFO read enable, active-low.
REQ-010 SHALL have port pix_data, output, 16: RGB565 pixel.
REQ-011 SHALL have port pix_valid, output, 1; pix_sof, output, 1 (first pixel of frame); pix_eol, output, 1 (last pixel of line).
REQ-012 SHALL have port out_ready, input, 1: downstream accepts pixel when pix_valid & out_ready.
REQ-013 SHALL have port busy, output, 1; frame_done, output, 1 (one-cycle pulse); overrun_cnt, output, 8.

Function
REQ-014 SHALL implement states IDLE, RRST, GAP, READ, DONE.
REQ-015 IDLE->RRST on frame_ready; RRST holds cam_rrst_n=0, cam_re_n=1 for exactly RRST_CYCLES cycles, then ->GAP.
REQ-016 GAP SHALL last one cycle with cam_rrst_n=1, cam_re_n=1, then ->READ.
REQ-017 FIFO read latency SHALL be one cycle: byte issued in cycle t (cam_re_n=0) is sampled from cam_data at the clk25 edge ending cycle t+1.
REQ-018 Reads SHALL alternate phase HI, LO starting with HI; HI byte -> pix_data[15:8], LO byte -> pix_data[7:0].
REQ-019 HI read SHALL issue every READ-state cycle in HI phase while bytes remain.
REQ-020 LO read SHALL issue only when pix_valid=0 or (pix_valid & out_ready) in that cycle; otherwise cam_re_n=1 and phase holds.
REQ-021 Pixel register SHALL load the cycle the LO byte is sampled; pix_valid rises next cycle and holds, with pix_data/pix_sof/pix_eol stable, until out_ready.
REQ-022 Max throughput SHALL be one pixel per 2 cycles; no byte is ever dropped or overwritten under any out_ready pattern.
REQ-023 Byte issue counter SHALL stop at exactly H_PIXELS*V_LINES*2 reads; then READ->DONE.
REQ-024 DONE SHALL wait until the last pixel is accepted, pulse frame_done one cycle, ->IDLE.
REQ-025 pix_sof=1 only on pixel (0,0); pix_eol=1 when column counter = H_PIXELS-1; column wraps to 0 and line increments on eol.
REQ-026 busy SHALL be 1 in all states except IDLE.
REQ-027 frame_ready while busy SHALL be ignored and increment overrun_cnt, saturating at 255.
REQ-028 frame_ready in the same cycle as frame_done SHALL count as overrun (state not yet IDLE).

Reset
REQ-029 On reset_n=0, immediately: state IDLE, cam_rrst_n=1, cam_re_n=1, pix_valid=0, pix_sof=0, pix_eol=0, pix_data=0, busy=0, frame_done=0, overrun_cnt=0, all counters/phase cleared.
REQ-030 Reset mid-frame SHALL abandon the frame; next frame_ready after release SHALL start a fresh RRST sequence.

Verification
REQ-031 H_PIXELS=4, V_LINES=2, out_ready=1, FIFO model bytes 0x00..0x0F -> pixels 0x0001,0x0203,...,0x0E0F; sof on first, eol on 4th and 8th; frame_done one pulse.
REQ-032 frame_ready pulse -> cam_rrst_n low exactly 4 cycles, cam_re_n high 5 cycles, first cam_re_n low the cycle after GAP.
REQ-033 out_ready random 30% -> pixel sequence identical to REQ-031, pix_data stable while stalled, total cam_re_n low cycles = 16.
REQ-034 Three frame_ready pulses during READ -> overrun_cnt=3, frame completes normally; 300 overruns -> overrun_cnt=255.
REQ-035 reset_n low during READ after 5 pixels -> outputs at reset values same cycle; next frame_ready yields full correct frame starting with pix_sof.

Source files
------------

// File: rtl/ov7670_fifo_reader.sv
// Reads one frame out of the AL422B camera FIFO byte by byte and pairs the bytes into
// RGB565 pixels on a valid/ready stream, with line and frame markers.
module ov7670_fifo_reader #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int RRST_CYCLES = 4
) (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic        frame_ready,
  input  logic [7:0]  cam_data,
  output logic        cam_rrst_n,
  output logic        cam_re_n,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt,
  output logic [2:0]  state_dbg
);

  // Pixel stream handshake: a pixel moves when pix_valid & out_ready at a rising clk25 edge;
  // once pix_valid is high, pix_data/pix_sof/pix_eol hold until that edge.

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RRST = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int TOTAL = H_PIXELS * V_LINES * 2;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int CW    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int LW    = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int RW    = (RRST_CYCLES > 1) ? $clog2(RRST_CYCLES) : 1;

  logic [2:0]    state;
  logic [RW-1:0] rrst_cnt;
  logic [BW-1:0] byte_cnt;
  logic          phase_lo;
  logic          rd_pend;
  logic          rd_lo;
  logic [7:0]    hi_byte;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic          issue;
  logic          load;

  // A LO read is only issued when the pixel register is guaranteed free by the time
  // its byte lands, so no pixel can ever be overwritten.
  always_comb begin
    issue = 1'b0;
    if (state == S_READ && byte_cnt != BW'(TOTAL))
      issue = !phase_lo || !pix_valid || out_ready;
  end

  assign load       = rd_pend && rd_lo;
  assign cam_re_n   = !issue;
  assign cam_rrst_n = (state != S_RRST);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rrst_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == S_DONE) && !frame_done && !rd_pend && (!pix_valid || out_ready);
      case (state)
        S_IDLE: begin
          rrst_cnt <= '0;
          if (frame_ready) state <= S_RRST;
        end
        S_RRST: begin
          if (rrst_cnt == RW'(RRST_CYCLES - 1)) state <= S_GAP;
          else rrst_cnt <= rrst_cnt + 1'b1;
        end
        S_GAP:  state <= S_READ;
        S_READ: if (issue && byte_cnt == BW'(TOTAL - 1)) state <= S_DONE;
        S_DONE: if (frame_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= '0;
    end else if (frame_ready && state != S_IDLE && overrun_cnt != 8'hff) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      phase_lo <= 1'b0;
      rd_pend  <= 1'b0;
      rd_lo    <= 1'b0;
      hi_byte  <= '0;
    end else begin
      rd_pend <= issue;
      rd_lo   <= issue && phase_lo;
      if (state == S_IDLE && frame_ready) begin
        byte_cnt <= '0;
        phase_lo <= 1'b0;
      end else if (issue) begin
        byte_cnt <= byte_cnt + 1'b1;
        phase_lo <= !phase_lo;
      end
      if (rd_pend && !rd_lo) hi_byte <= cam_data;
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      col       <= '0;
      line      <= '0;
    end else begin
      if (state == S_IDLE && frame_ready) begin
        col  <= '0;
        line <= '0;
      end else if (load) begin
        if (col == CW'(H_PIXELS - 1)) begin
          col  <= '0;
          line <= (line == LW'(V_LINES - 1)) ? '0 : line + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (load) begin
        pix_data  <= {hi_byte, cam_data};
        pix_valid <= 1'b1;
        pix_sof   <= (col == '0) && (line == '0);
        pix_eol   <= (col == CW'(H_PIXELS - 1));
      end else if (pix_valid && out_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_fifo_reader.sv
// Directed bench for ov7670_fifo_reader on a 4x2 frame with a byte-counting FIFO model.
module tb_ov7670_fifo_reader;

  localparam int H = 4;
  localparam int V = 2;
  localparam int NPIX = H * V;

  logic        clk25 = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_ready = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        cam_rrst_n, cam_re_n;
  logic [15:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol;
  logic        out_ready = 1'b1;
  logic        busy, frame_done;
  logic [7:0]  overrun_cnt;
  logic [2:0]  state_dbg;

  ov7670_fifo_reader #(.H_PIXELS(H), .V_LINES(V), .RRST_CYCLES(4)) dut (
    .clk25(clk25), .reset_n(reset_n), .frame_ready(frame_ready), .cam_data(cam_data),
    .cam_rrst_n(cam_rrst_n), .cam_re_n(cam_re_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .out_ready(out_ready), .busy(busy),
    .frame_done(frame_done), .overrun_cnt(overrun_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk25 = ~clk25;

  // AL422B read side: data for a read issued in cycle t is valid throughout cycle t+1
  logic [3:0] rptr = 4'd0;
  always @(posedge clk25) begin
    if (!cam_rrst_n) rptr <= 4'd0;
    else if (!cam_re_n) begin
      cam_data <= {4'h0, rptr};
      rptr     <= rptr + 4'd1;
    end
  end

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } pix_vec_t;

  typedef struct {
    logic rrst_n;
    logic re_n;
    logic busy;
  } ctl_vec_t;

  pix_vec_t   pix_tab [NPIX];
  ctl_vec_t   ctl_tab [6];
  logic [17:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int re_low   = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  bit mon_en   = 1'b0;
  bit rand_en  = 1'b0;
  bit prev_stall = 1'b0;
  logic [17:0] prev_pix = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: pixels accepted in order, and held stable while stalled
  always @(negedge clk25) begin
    if (mon_en) begin
      if (!cam_re_n) re_low++;
      if (frame_done) done_cnt++;
      if (prev_stall && pix_valid)
        check("pix_stable", {14'd0, pix_sof, pix_eol, pix_data}, {14'd0, prev_pix});
      if (pix_valid && out_ready) begin
        if (exp_q.size() == 0) check("pix_extra", 32'd1, 32'd0);
        else check("pix", {14'd0, pix_sof, pix_eol, pix_data}, {14'd0, exp_q.pop_front()});
        acc_cnt++;
      end
      prev_stall = pix_valid && !out_ready;
      prev_pix   = {pix_sof, pix_eol, pix_data};
    end
  end

  always @(posedge clk25) begin
    if (rand_en) begin
      #1 out_ready = ($urandom_range(0, 99) >= 30);
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_rrst_n"}, {31'd0, cam_rrst_n}, 32'd1);
    check({tag, "_re_n"}, {31'd0, cam_re_n}, 32'd1);
    check({tag, "_valid_sof_eol"}, {29'd0, pix_valid, pix_sof, pix_eol}, 32'd0);
    check({tag, "_data"}, {16'd0, pix_data}, 32'd0);
    check({tag, "_busy_done"}, {30'd0, busy, frame_done}, 32'd0);
    check({tag, "_overrun"}, {24'd0, overrun_cnt}, 32'd0);
    check({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk25);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1 check_reset_values(tag);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge clk25);
    #1 reset_n = 1'b1;
  endtask

  task automatic pulse_frame_ready();
    @(posedge clk25);
    #1 frame_ready = 1'b1;
    @(posedge clk25);
    #1 frame_ready = 1'b0;
  endtask

  task automatic start_frame();
    for (int i = 0; i < NPIX; i++) exp_q.push_back({pix_tab[i].sof, pix_tab[i].eol, pix_tab[i].data});
    re_low = 0;
    done_cnt = 0;
    acc_cnt = 0;
    mon_en = 1'b1;
    pulse_frame_ready();
  endtask

  task automatic finish_frame(input string tag);
    int budget;
    budget = 400;
    while (done_cnt == 0 && budget > 0) begin
      @(posedge clk25);
      budget--;
    end
    check({tag, "_done_timeout"}, {31'd0, (budget == 0)}, 32'd0);
    repeat (3) @(negedge clk25);
    check({tag, "_left_in_q"}, exp_q.size(), 32'd0);
    check({tag, "_re_low"}, re_low, 32'd16);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      pix_tab[i].data = {8'(2 * i), 8'(2 * i + 1)};
      pix_tab[i].sof  = (i == 0);
      pix_tab[i].eol  = (i % H == H - 1);
    end
    // four cycles of RRST, one GAP cycle, then the first HI read
    ctl_tab[0] = '{1'b0, 1'b1, 1'b1};
    ctl_tab[1] = '{1'b0, 1'b1, 1'b1};
    ctl_tab[2] = '{1'b0, 1'b1, 1'b1};
    ctl_tab[3] = '{1'b0, 1'b1, 1'b1};
    ctl_tab[4] = '{1'b1, 1'b1, 1'b1};
    ctl_tab[5] = '{1'b1, 1'b0, 1'b1};

    #3 check_reset_values("por");
    repeat (2) @(posedge clk25);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk25);

    // nominal frame with the read-reset preamble checked cycle by cycle
    start_frame();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk25);
      check($sformatf("pre%0d_rrst_n", k), {31'd0, cam_rrst_n}, {31'd0, ctl_tab[k].rrst_n});
      check($sformatf("pre%0d_re_n", k), {31'd0, cam_re_n}, {31'd0, ctl_tab[k].re_n});
      check($sformatf("pre%0d_busy", k), {31'd0, busy}, {31'd0, ctl_tab[k].busy});
    end
    finish_frame("nominal");

    // random 30% back-pressure
    rand_en = 1'b1;
    start_frame();
    finish_frame("stall");
    rand_en = 1'b0;
    @(posedge clk25);
    #2 out_ready = 1'b1;

    // frame_ready pulses while reading are ignored and counted
    start_frame();
    begin
      int budget;
      budget = 50;
      while (cam_re_n && budget > 0) begin
        @(negedge clk25);
        budget--;
      end
      check("ovr_read_timeout", {31'd0, (budget == 0)}, 32'd0);
    end
    repeat (3) pulse_frame_ready();
    @(negedge clk25);
    check("ovr_three", {24'd0, overrun_cnt}, 32'd3);
    finish_frame("ovr");
    check("ovr_three_after", {24'd0, overrun_cnt}, 32'd3);

    // saturation: hold the reader busy with out_ready low and request 300 times
    out_ready = 1'b0;
    start_frame();
    repeat (20) @(posedge clk25);
    #1 frame_ready = 1'b1;
    repeat (300) @(posedge clk25);
    #1 frame_ready = 1'b0;
    @(negedge clk25);
    check("ovr_sat", {24'd0, overrun_cnt}, 32'd255);
    check("ovr_sat_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    finish_frame("sat");
    check("ovr_sat_after", {24'd0, overrun_cnt}, 32'd255);

    // frame_ready coinciding with frame_done counts as an overrun and starts nothing
    apply_reset("rst_a");
    @(posedge clk25);
    start_frame();
    begin
      int budget;
      budget = 400;
      while (!frame_done && budget > 0) begin
        @(negedge clk25);
        budget--;
      end
      check("coinc_timeout", {31'd0, (budget == 0)}, 32'd0);
    end
    frame_ready = 1'b1;
    @(posedge clk25);
    #1 frame_ready = 1'b0;
    @(negedge clk25);
    check("coinc_overrun", {24'd0, overrun_cnt}, 32'd1);
    check("coinc_idle", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk25);
    check("coinc_no_rrst", {30'd0, cam_rrst_n, busy}, 32'd2);
    check("coinc_q", exp_q.size(), 32'd0);

    // reset in the middle of a frame, then a clean frame
    start_frame();
    begin
      int budget;
      budget = 200;
      while (acc_cnt < 5 && budget > 0) begin
        @(posedge clk25);
        budget--;
      end
      check("mid_timeout", {31'd0, (budget == 0)}, 32'd0);
    end
    apply_reset("rst_mid");
    repeat (2) @(posedge clk25);
    start_frame();
    finish_frame("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
